color_match_judge: RTL and testbench
====================================

# color_match_judge

Round controller and scorer sitting directly downstream of the platform/ball colour randomiser. It requests a colour round and captures the randomiser's 12-bit platform colours and 3-bit ball colour. It then waits for the physics/collision stage to report which platform the ball landed on, judges whether the colours match, and maintains score, lives and game-over. Outputs feed the VGA draw and HEX display stages.

## Interface
- LIVES_INIT, 3: lives loaded at reset and on game start; legal range 1..3.
- SCORE_W, 8: score counter width.
- clk  in  1  system clock; all state changes on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  start/restart request; honoured only in IDLE or OVER.
- round_colors  in  12  platform colours: [2:0] platform 0, [5:3] platform 1, [8:6] platform 2, [11:9] platform 3.
- ball_color  in  3  ball colour from the randomiser.
- land_valid  in  1  single-cycle strobe: ball has landed this cycle.
- land_plat  in  2  platform index landed on; qualified by land_valid.
- new_round_req  out  1  one-cycle pulse telling the randomiser to present a new round.
- round_active  out  1  high while captured colours are valid and landing is awaited.
- cur_plats  out  12  captured platform colours, for the draw stage.
- cur_ball  out  3  captured ball colour.
- hit  out  1  one-cycle pulse on a colour match.
- miss  out  1  one-cycle pulse on a mismatch.
- score  out  SCORE_W  hits this game; saturates at all-ones.
- lives  out  2  remaining lives.
- game_over  out  1  high in OVER.

## Operation
- States are IDLE, REQ, LOAD, WAIT_LAND, JUDGE and OVER.
- **IDLE**: on start, set score to 0 and lives to LIVES_INIT, then go to REQ.
- **REQ**: assert new_round_req for exactly this cycle, then go to LOAD.
- **LOAD**: sample round_colors and ball_color into cur_plats and cur_ball.
  - A round is valid when ball_color != 3'b000 (black) and at least one 3-bit platform slice equals ball_color.
  - Valid round: go to WAIT_LAND.
  - Invalid round: go back to REQ. Re-requesting is unbounded, and score and lives are untouched.
- **WAIT_LAND**: round_active = 1. On land_valid, latch land_plat and go to JUDGE. land_valid in any other state is ignored.
- **JUDGE**: compare cur_plats[3*land_plat +: 3] with cur_ball.
  - Equal: set hit, score += 1 (held at max, no wrap), go to REQ.
  - Not equal: set miss, lives -= 1. If the new lives value is 0, go to OVER, otherwise go to REQ.
- **OVER**: game_over = 1, and score and lives are held. On start, reload score and lives exactly as IDLE does and go to REQ.
- start is ignored in REQ, LOAD, WAIT_LAND and JUDGE.
- lives never underflows, because OVER is entered at 0.
- Reset values: state IDLE, score 0, lives LIVES_INIT, cur_plats 0, cur_ball 0. All strobes and flags (new_round_req, round_active, hit, miss, game_over) are 0.
- Reset asserted mid-round aborts the round immediately, with no hit/miss pulse.

## Timing
- All outputs are registered or decoded from registered state only; there is no combinational input-to-output path.
- start sampled at edge N: new_round_req is high during cycle N+1.
- round_colors and ball_color are sampled at the edge that leaves LOAD. The randomiser must hold them stable from the cycle after new_round_req until that edge.
- land_valid sampled at edge N: JUDGE runs during cycle N+1. hit or miss is high during cycle N+2, score and lives show new values from cycle N+2, and new_round_req is high during cycle N+2 unless the game is over.
- Minimum round period is 4 cycles, plus the landing wait.
- hit and miss are never high in the same cycle.

## Structure
- Shared package `color_pkg`:
  - state enum
  - COLOR_W = 3
  - NUM_PLATS = 4
  - COLOR_BLACK = 3'b000
- Sub-module `plat_color_sel`: combinational 12-to-3 slice selector by 2-bit index, also used by the draw stage. The "any platform matches" check is the OR of its four equality compares, done inline.

## Test plan
- Reset then start; in LOAD, round_colors = 12'o1234 and ball_color = 3'o3; land_plat = 1 -> hit pulse at N+2, score 0 to 1, lives 3, new_round_req at N+2.
- Same round, land_plat = 0 -> miss pulse, lives 3 to 2, score unchanged.
- ball_color = 0 in LOAD, then round_colors = 12'o1111 with ball_color = 3'o5 -> two consecutive re-requests, round_active stays low, score and lives unchanged.
- Three misses starting from lives 3 -> game_over high after the third miss, no further new_round_req, and land_valid/start pulses in OVER other than start are ignored. Then start -> lives 3, score 0, new_round_req next cycle.
- Force score to 8'hFF and land a hit -> score stays 8'hFF and a hit pulse is still produced.
- Deassert resetn during WAIT_LAND -> all outputs at reset values asynchronously, state IDLE, no hit/miss pulse after release.

Source files
------------

// File: rtl/color_pkg.sv
// Shared types and constants for the colour-match round controller and its draw-side helpers.
package color_pkg;

    localparam int unsigned COLOR_W   = 3;
    localparam int unsigned NUM_PLATS = 4;
    localparam int unsigned PLATS_W   = COLOR_W * NUM_PLATS;
    localparam int unsigned IDX_W     = 2;
    localparam int unsigned LIVES_W   = 2;

    localparam logic [COLOR_W-1:0] COLOR_BLACK = 3'b000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_LOAD,
        ST_WAIT_LAND,
        ST_JUDGE,
        ST_OVER
    } state_t;

endpackage

// File: rtl/plat_color_sel.sv
// Picks one platform's 3-bit colour out of the packed 12-bit platform word.
module plat_color_sel
    import color_pkg::*;
(
    input  logic [PLATS_W-1:0] plats,
    input  logic [IDX_W-1:0]   idx,
    output logic [COLOR_W-1:0] sel_color_c
);

    always_comb begin
        sel_color_c = plats[COLOR_W*32'(idx) +: COLOR_W];
    end

endmodule

// File: rtl/color_match_judge.sv
// Round controller and scorer: requests a colour round, captures it, judges the landing
// platform against the ball colour and keeps score, lives and game-over for display.
module color_match_judge
    import color_pkg::*;
#(
    parameter int unsigned LIVES_INIT = 3,
    parameter int unsigned SCORE_W    = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [PLATS_W-1:0]   round_colors,
    input  logic [COLOR_W-1:0]   ball_color,
    input  logic                 land_valid,
    input  logic [IDX_W-1:0]     land_plat,
    output logic                 new_round_req,
    output logic                 round_active,
    output logic [PLATS_W-1:0]   cur_plats,
    output logic [COLOR_W-1:0]   cur_ball,
    output logic                 hit,
    output logic                 miss,
    output logic [SCORE_W-1:0]   score,
    output logic [LIVES_W-1:0]   lives,
    output logic                 game_over
);

    localparam logic [LIVES_W-1:0] LIVES_RST = LIVES_W'(LIVES_INIT);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     land_plat_q, land_plat_d;
    logic [PLATS_W-1:0]   cur_plats_d;
    logic [COLOR_W-1:0]   cur_ball_d;
    logic [SCORE_W-1:0]   score_d;
    logic [LIVES_W-1:0]   lives_d;
    logic                 hit_d, miss_d;
    logic                 plat_match_c;
    logic                 round_valid_c;
    logic [COLOR_W-1:0]   judge_color_c;

    plat_color_sel u_judge_sel (
        .plats       (cur_plats),
        .idx         (land_plat_q),
        .sel_color_c (judge_color_c)
    );

    // A round is playable only if the ball is coloured and some platform carries that colour.
    always_comb begin
        plat_match_c = 1'b0;
        for (int unsigned i = 0; i < NUM_PLATS; i++) begin
            if (round_colors[i*COLOR_W +: COLOR_W] == ball_color) begin
                plat_match_c = 1'b1;
            end
        end
        round_valid_c = (ball_color != COLOR_BLACK) && plat_match_c;
    end

    always_comb begin
        state_d     = state_q;
        land_plat_d = land_plat_q;
        cur_plats_d = cur_plats;
        cur_ball_d  = cur_ball;
        score_d     = score;
        lives_d     = lives;
        hit_d       = 1'b0;
        miss_d      = 1'b0;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    score_d = '0;
                    lives_d = LIVES_RST;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                cur_plats_d = round_colors;
                cur_ball_d  = ball_color;
                state_d     = round_valid_c ? ST_WAIT_LAND : ST_REQ;
            end
            ST_WAIT_LAND: begin
                if (land_valid) begin
                    land_plat_d = land_plat;
                    state_d     = ST_JUDGE;
                end
            end
            ST_JUDGE: begin
                if (judge_color_c == cur_ball) begin
                    hit_d   = 1'b1;
                    state_d = ST_REQ;
                    if (score != SCORE_MAX) begin
                        score_d = score + SCORE_W'(1);
                    end
                end else begin
                    miss_d  = 1'b1;
                    lives_d = lives - LIVES_W'(1);
                    state_d = (lives == LIVES_W'(1)) ? ST_OVER : ST_REQ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Flags are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            land_plat_q   <= '0;
            cur_plats     <= '0;
            cur_ball      <= '0;
            score         <= '0;
            lives         <= LIVES_RST;
            hit           <= 1'b0;
            miss          <= 1'b0;
            new_round_req <= 1'b0;
            round_active  <= 1'b0;
            game_over     <= 1'b0;
        end else begin
            state_q       <= state_d;
            land_plat_q   <= land_plat_d;
            cur_plats     <= cur_plats_d;
            cur_ball      <= cur_ball_d;
            score         <= score_d;
            lives         <= lives_d;
            hit           <= hit_d;
            miss          <= miss_d;
            new_round_req <= (state_d == ST_REQ);
            round_active  <= (state_d == ST_WAIT_LAND);
            game_over     <= (state_d == ST_OVER);
        end
    end

endmodule

// File: tb/tb_color_match_judge.sv
// Self-checking bench for color_match_judge: directed table, corner sequences and random rounds.
module tb_color_match_judge;

    logic        clk;
    logic        resetn;
    logic        start;
    logic [11:0] round_colors;
    logic [2:0]  ball_color;
    logic        land_valid;
    logic [1:0]  land_plat;
    logic        new_round_req;
    logic        round_active;
    logic [11:0] cur_plats;
    logic [2:0]  cur_ball;
    logic        hit;
    logic        miss;
    logic [7:0]  score;
    logic [1:0]  lives;
    logic        game_over;

    int errors = 0;
    int checks = 0;

    int exp_score;
    int exp_lives;
    logic exp_over;

    typedef struct {
        logic [11:0] colors;
        logic [2:0]  ball;
        logic [1:0]  plat;
        logic        exp_hit;
        logic [7:0]  exp_score;
        logic [1:0]  exp_lives;
    } vec_t;

    vec_t vecs[6];

    color_match_judge #(
        .LIVES_INIT (3),
        .SCORE_W    (8)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .start         (start),
        .round_colors  (round_colors),
        .ball_color    (ball_color),
        .land_valid    (land_valid),
        .land_plat     (land_plat),
        .new_round_req (new_round_req),
        .round_active  (round_active),
        .cur_plats     (cur_plats),
        .cur_ball      (cur_ball),
        .hit           (hit),
        .miss          (miss),
        .score         (score),
        .lives         (lives),
        .game_over     (game_over)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    function automatic logic [2:0] slice_of(input logic [11:0] c, input int p);
        return 3'(c >> (3 * p));
    endfunction

    // Entered in the cycle new_round_req is high; leaves in the cycle after the judgement.
    task automatic do_round(input logic [11:0] c, input logic [2:0] b, input logic [1:0] p,
                            input int w, input logic eh, input logic [7:0] es,
                            input logic [1:0] el, input logic eo, input logic poke_start);
        check("req_before_round", 32'(new_round_req), 32'd1);
        round_colors = c;
        ball_color   = b;
        step();
        check("load_not_active", 32'(round_active), 32'd0);
        step();
        check("round_active", 32'(round_active), 32'd1);
        check("cur_plats", 32'(cur_plats), 32'(c));
        check("cur_ball", 32'(cur_ball), 32'(b));
        for (int k = 0; k < w; k++) begin
            start = poke_start;
            step();
            check("wait_active", 32'(round_active), 32'd1);
        end
        start        = 1'b0;
        land_valid   = 1'b1;
        land_plat    = p;
        step();
        land_valid   = 1'b0;
        land_plat    = ~p;
        round_colors = ~c;
        check("judge_quiet", 32'({hit, miss, new_round_req}), 32'd0);
        step();
        check("hit", 32'(hit), 32'(eh));
        check("miss", 32'(miss), 32'(!eh));
        check("score", 32'(score), 32'(es));
        check("lives", 32'(lives), 32'(el));
        check("game_over", 32'(game_over), 32'(eo));
        check("next_req", 32'(new_round_req), 32'(!eo));
    endtask

    // Unplayable round: expect an immediate re-request with nothing else moving.
    task automatic do_invalid(input logic [11:0] c, input logic [2:0] b,
                              input logic [7:0] es, input logic [1:0] el);
        check("req_before_invalid", 32'(new_round_req), 32'd1);
        round_colors = c;
        ball_color   = b;
        land_valid   = 1'b1;
        step();
        land_valid   = 1'b0;
        step();
        check("rereq", 32'(new_round_req), 32'd1);
        check("rereq_inactive", 32'(round_active), 32'd0);
        check("rereq_score", 32'(score), 32'(es));
        check("rereq_lives", 32'(lives), 32'(el));
        check("rereq_no_pulse", 32'({hit, miss}), 32'd0);
    endtask

    task automatic restart();
        start = 1'b1;
        step();
        start = 1'b0;
        check("restart_req", 32'(new_round_req), 32'd1);
        check("restart_score", 32'(score), 32'd0);
        check("restart_lives", 32'(lives), 32'd3);
        check("restart_over", 32'(game_over), 32'd0);
        exp_score = 0;
        exp_lives = 3;
        exp_over  = 1'b0;
    endtask

    initial begin
        logic [11:0] c;
        logic [2:0]  b;
        logic [1:0]  p;
        logic        valid;
        logic        eh;
        int          pf;

        vecs[0] = '{12'o1234, 3'o3, 2'd1, 1'b1, 8'd1, 2'd3};
        vecs[1] = '{12'o1234, 3'o3, 2'd0, 1'b0, 8'd1, 2'd2};
        vecs[2] = '{12'o7654, 3'o5, 2'd1, 1'b1, 8'd2, 2'd2};
        vecs[3] = '{12'o7654, 3'o6, 2'd3, 1'b0, 8'd2, 2'd1};
        vecs[4] = '{12'o0070, 3'o7, 2'd1, 1'b1, 8'd3, 2'd1};
        vecs[5] = '{12'o2222, 3'o2, 2'd0, 1'b1, 8'd4, 2'd1};

        clk          = 1'b0;
        resetn       = 1'b0;
        start        = 1'b0;
        round_colors = '0;
        ball_color   = '0;
        land_valid   = 1'b0;
        land_plat    = '0;

        repeat (2) step();
        check("rst_req", 32'(new_round_req), 32'd0);
        check("rst_active", 32'(round_active), 32'd0);
        check("rst_plats", 32'(cur_plats), 32'd0);
        check("rst_ball", 32'(cur_ball), 32'd0);
        check("rst_pulses", 32'({hit, miss}), 32'd0);
        check("rst_score", 32'(score), 32'd0);
        check("rst_lives", 32'(lives), 32'd3);
        check("rst_over", 32'(game_over), 32'd0);

        resetn = 1'b1;
        land_valid = 1'b1;
        step();
        land_valid = 1'b0;
        step();
        check("idle_no_req", 32'(new_round_req), 32'd0);

        restart();
        for (int i = 0; i < 6; i++) begin
            do_round(vecs[i].colors, vecs[i].ball, vecs[i].plat, i % 3, vecs[i].exp_hit,
                     vecs[i].exp_score, vecs[i].exp_lives, 1'b0, 1'b1);
        end

        do_invalid(12'o4321, 3'o0, 8'd4, 2'd1);
        do_invalid(12'o1111, 3'o5, 8'd4, 2'd1);

        // Last life lost: game over, then nothing but start moves the controller.
        do_round(12'o1234, 3'o3, 2'd0, 1, 1'b0, 8'd4, 2'd0, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            land_valid = k[0];
            land_plat  = 2'(k);
            step();
            check("over_hold", 32'(game_over), 32'd1);
            check("over_no_req", 32'(new_round_req), 32'd0);
            check("over_score", 32'(score), 32'd4);
            check("over_lives", 32'(lives), 32'd0);
        end
        land_valid = 1'b0;

        restart();
        do_round(12'o1234, 3'o3, 2'd0, 0, 1'b0, 8'd0, 2'd2, 1'b0, 1'b1);
        do_round(12'o1234, 3'o3, 2'd2, 2, 1'b0, 8'd0, 2'd1, 1'b0, 1'b1);
        do_round(12'o1234, 3'o3, 2'd3, 0, 1'b0, 8'd0, 2'd0, 1'b1, 1'b0);
        restart();

        for (int r = 0; r < 150; r++) begin
            if (exp_over) restart();
            c = 12'($urandom);
            b = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) != 0) begin
                pf = $urandom_range(0, 3);
                c  = (c & ~(12'h7 << (3 * pf))) | (12'(b) << (3 * pf));
            end
            valid = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (b != 3'd0 && slice_of(c, i) == b) valid = 1'b1;
            end
            if (!valid) begin
                do_invalid(c, b, 8'(exp_score), 2'(exp_lives));
            end else begin
                p = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 1) == 1) begin
                    for (int i = 3; i >= 0; i--) begin
                        if (slice_of(c, i) == b) p = 2'(i);
                    end
                end
                eh = (slice_of(c, int'(p)) == b);
                if (eh) begin
                    if (exp_score < 255) exp_score++;
                end else begin
                    exp_lives--;
                    if (exp_lives == 0) exp_over = 1'b1;
                end
                do_round(c, b, p, $urandom_range(0, 3), eh, 8'(exp_score), 2'(exp_lives),
                         exp_over, 1'($urandom_range(0, 1)));
            end
        end
        if (exp_over) restart();

        // Score saturation: keep hitting well past all-ones.
        while (exp_score < 255) begin
            exp_score++;
            do_round(12'o1234, 3'o3, 2'd1, 0, 1'b1, 8'(exp_score), 2'(exp_lives), 1'b0, 1'b0);
        end
        do_round(12'o1234, 3'o3, 2'd1, 0, 1'b1, 8'hFF, 2'(exp_lives), 1'b0, 1'b0);
        do_round(12'o5555, 3'o5, 2'd2, 1, 1'b1, 8'hFF, 2'(exp_lives), 1'b0, 1'b0);

        // Reset in WAIT_LAND with a landing pending: asynchronous clear, no late pulse.
        round_colors = 12'o1234;
        ball_color   = 3'o3;
        step();
        step();
        check("pre_rst_active", 32'(round_active), 32'd1);
        land_valid = 1'b1;
        land_plat  = 2'd1;
        #2 resetn = 1'b0;
        #1;
        check("async_active", 32'(round_active), 32'd0);
        check("async_plats", 32'(cur_plats), 32'd0);
        check("async_ball", 32'(cur_ball), 32'd0);
        check("async_score", 32'(score), 32'd0);
        check("async_lives", 32'(lives), 32'd3);
        check("async_flags", 32'({new_round_req, hit, miss, game_over}), 32'd0);
        land_valid = 1'b0;
        step();
        step();
        resetn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check("post_rst_quiet", 32'({new_round_req, round_active, hit, miss, game_over}), 32'd0);
        end
        restart();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
